// File: rtl/apb_reg_pkg.sv
// rtl/apb_reg_pkg.sv - shared types and constants for the APB register bridge
package apb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] DATA_REGION = 8'h00;
    localparam logic [5:0] ID_REGION   = 6'h3F;
    localparam int         CNT_W       = 4;

endpackage

// File: rtl/apb_reg_decode.sv
// rtl/apb_reg_decode.sv - combinational mapped/read-only decode of a register byte address
module apb_reg_decode
    import apb_reg_pkg::*;
(
    input  logic [11:0] addr,
    output logic        mapped,
    output logic        read_only
);

    logic in_data;
    logic in_id;

    assign in_data   = (addr[11:4] == DATA_REGION);
    assign in_id     = (addr[11:6] == ID_REGION);
    assign mapped    = in_data | in_id;
    assign read_only = in_id;

endmodule

// File: rtl/apb_reg_bridge.sv
// rtl/apb_reg_bridge.sv - APB3 slave to single-cycle register strobes; APB_REG_BRIDGE_DECERR_EN enables decode errors
module apb_reg_bridge
    import apb_reg_pkg::*;
#(
    parameter int ADDRWIDTH   = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [ADDRWIDTH-1:0] addr,
    output logic                 read_en,
    output logic                 write_en,
    output logic [31:0]          wdata,
    input  logic [31:0]          rdata
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir, dir_nxt;
    logic             err, err_nxt;
    logic             setup;
    logic             unmapped;

    assign setup = psel & ~penable;

`ifdef APB_REG_BRIDGE_DECERR_EN
    logic mapped;
    logic read_only;

    apb_reg_decode u_decode (
        .addr      (paddr[11:0]),
        .mapped    (mapped),
        .read_only (read_only)
    );

    assign unmapped = ~mapped | (read_only & pwrite);
`else
    assign unmapped = 1'b0;
    assign pslverr  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (setup) begin
                    dir_nxt = pwrite;
                    err_nxt = unmapped;
                    cnt_nxt = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0)
                        state_nxt = WAIT;
                    else if (unmapped)
                        state_nxt = DONE;
                    else
                        state_nxt = ISSUE;
                end
            end
            WAIT: begin
                // An abandoned transfer has not touched the register block yet.
                if (!psel)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))
                    state_nxt = err ? DONE : ISSUE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            cnt      <= '0;
            dir      <= 1'b0;
            err      <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            prdata   <= '0;
            pready   <= 1'b0;
            read_en  <= 1'b0;
            write_en <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
            err   <= err_nxt;
            if (state == IDLE && setup) begin
                addr  <= paddr;
                wdata <= pwdata;
            end
            // Strobes and pready are registered from the next state so they line up with it.
            read_en  <= (state_nxt == ISSUE) & ~dir_nxt;
            write_en <= (state_nxt == ISSUE) & dir_nxt;
            pready   <= (state_nxt == DONE);
            prdata   <= (state == ISSUE && !dir) ? rdata : 32'h0;
        end
    end

`ifdef APB_REG_BRIDGE_DECERR_EN
    always_ff @(posedge pclk) begin
        if (preset)
            pslverr <= 1'b0;
        else
            pslverr <= (state_nxt == DONE) & err_nxt;
    end
`endif

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb/tb_apb_reg_bridge.sv - scoreboard bench for apb_reg_bridge at WAIT_CYCLES 0, 3 and 2
module tb_apb_reg_bridge;

    typedef struct {
        logic [31:0] prdata;
        logic        pslverr;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel     [3];
    logic        penable  [3];
    logic        pwrite   [3];
    logic [11:0] paddr    [3];
    logic [31:0] pwdata   [3];
    logic [31:0] prdata   [3];
    logic        pready   [3];
    logic        pslverr  [3];
    logic [11:0] addr     [3];
    logic        read_en  [3];
    logic        write_en [3];
    logic [31:0] wdata    [3];
    logic [31:0] rdata    [3];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 pclk = ~pclk;

    apb_reg_bridge #(.ADDRWIDTH(12), .WAIT_CYCLES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .addr(addr[0]), .read_en(read_en[0]),
        .write_en(write_en[0]), .wdata(wdata[0]), .rdata(rdata[0])
    );

    apb_reg_bridge #(.ADDRWIDTH(12), .WAIT_CYCLES(3)) u_dut1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .addr(addr[1]), .read_en(read_en[1]),
        .write_en(write_en[1]), .wdata(wdata[1]), .rdata(rdata[1])
    );

    apb_reg_bridge #(.ADDRWIDTH(12), .WAIT_CYCLES(2)) u_dut2 (
        .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]), .addr(addr[2]), .read_en(read_en[2]),
        .write_en(write_en[2]), .wdata(wdata[2]), .rdata(rdata[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 2;
    endfunction

    function automatic bit model_err(input bit wr, input logic [11:0] a);
`ifdef APB_REG_BRIDGE_DECERR_EN
        bit data_hit;
        bit id_hit;
        data_hit = (a[11:4] == 8'h00);
        id_hit   = (a[11:6] == 6'h3F);
        return !(data_hit || (id_hit && !wr));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_quiet(input int d, input string pfx);
        check({pfx, "_prdata"}, prdata[d], 32'h0);
        check({pfx, "_wdata"}, wdata[d], 32'h0);
        check({pfx, "_ctl"}, {16'h0, addr[d], pready[d], pslverr[d], read_en[d], write_en[d]}, 32'h0);
    endtask

    task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] rd);
        int   w;
        int   n;
        int   strobes;
        bit   er;
        bit   done;
        exp_t e;
        w  = wait_of(d);
        er = model_err(wr, a);
        e.prdata  = (wr || er) ? 32'h0 : rd;
        e.pslverr = er;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; rdata[d] = rd;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        n = 1; strobes = 0; done = 1'b0;
        while (!done && n <= 40) begin
            @(negedge pclk);
            if (read_en[d] || write_en[d]) begin
                strobes++;
                check("strobe_cyc", n, w + 1);
                check("strobe_dir", {read_en[d], write_en[d]}, wr ? 32'd1 : 32'd2);
                check("strobe_addr", addr[d], a);
                if (wr) check("strobe_wdata", wdata[d], wd);
            end
            if (pready[d]) begin
                done = 1'b1;
                e = exp_q.pop_front();
                check("pready_cyc", n, er ? w + 1 : w + 2);
                check("prdata", prdata[d], e.prdata);
                check("pslverr", pslverr[d], e.pslverr);
            end else begin
                @(posedge pclk); #1;
                n++;
            end
        end
        check("pready_seen", done, 1);
        if (!done && exp_q.size() > 0) e = exp_q.pop_front();
        check("strobe_count", strobes, er ? 0 : 1);
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(negedge pclk);
        check("after_prdata", prdata[d], 32'h0);
        check("after_pready", pready[d], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        preset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0;
            paddr[i] = '0; pwdata[i] = '0; rdata[i] = '0;
        end
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        for (int i = 0; i < 3; i++) check_quiet(i, "reset");

        xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 32'h0);
        xfer(0, 1'b0, 12'h008, 32'h0, 32'h12345678);
        xfer(1, 1'b0, 12'h000, 32'h0, 32'h0BADF00D);
        xfer(1, 1'b1, 12'h00C, 32'h55AA33CC, 32'hFFFFFFFF);

        // psel drops while the DUT is still counting wait cycles
        @(posedge pclk); #1;
        psel[2] = 1; penable[2] = 0; pwrite[2] = 0; paddr[2] = 12'h008; rdata[2] = 32'h77777777;
        @(posedge pclk); #1;
        psel[2] = 0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            seen = seen | read_en[2] | write_en[2] | pready[2];
            @(posedge pclk); #1;
        end
        check("abort_quiet", seen, 1'b0);
        xfer(2, 1'b0, 12'h00C, 32'h0, 32'hC0FFEE01);

        // reset lands while the write strobe is up
        @(posedge pclk); #1;
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 12'h004; pwdata[0] = 32'hCAFEF00D;
        @(posedge pclk); #1;
        penable[0] = 1;
        preset = 1'b1;
        @(negedge pclk);
        check("rst_issue_we", write_en[0], 1'b1);
        @(posedge pclk); #1;
        preset = 1'b0; psel[0] = 0; penable[0] = 0;
        @(negedge pclk);
        check_quiet(0, "rst_mid");
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            @(negedge pclk);
            seen = seen | write_en[0] | pready[0];
        end
        check("rst_no_second", seen, 1'b0);
        xfer(0, 1'b0, 12'h00C, 32'h0, 32'hA5A50F0F);

`ifdef APB_REG_BRIDGE_DECERR_EN
        xfer(0, 1'b0, 12'h100, 32'h0, 32'h11111111);
        xfer(0, 1'b1, 12'hFD0, 32'h22222222, 32'h0);
        xfer(0, 1'b0, 12'hFE0, 32'h0, 32'h1D000001);
        xfer(1, 1'b0, 12'h100, 32'h0, 32'h33333333);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
